// File: rtl/demo_depack_pkg.sv
// Shared types and helpers for the demo_depack_n serial-to-parallel deserializer.
package demo_depack_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

    // Counter must hold 0..WIDTH inclusive (WIDTH data bits plus an optional parity slot).
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of a level input.
module edge_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= in;
        end
    end

    assign rise = in & ~r_prev;

endmodule

// File: rtl/demo_depack_n.sv
// Parametrised serial-to-parallel deserializer with rotate and frame latch.
// Optional trailing parity bit per frame is compiled in with DEPACK_PARITY_EN.
module demo_depack_n
    import demo_depack_pkg::*;
#(
    parameter int unsigned  WIDTH      = 8,
    parameter bit           ODD_PARITY = PARITY_EVEN,
    localparam int unsigned CNT_W      = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             datain,
    input  logic             shift,
    input  logic             lsb_first,
    input  logic             clr,
    output logic [WIDTH-1:0] dataout,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_valid,
    output logic [CNT_W-1:0] bit_cnt
`ifdef DEPACK_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_frame_data;
    logic             r_frame_valid;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_shift_flag;
    bit_order_e       w_order;
    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] w_ins;
    logic             w_last_data;

    edge_rise_det u_shift_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (shift),
        .rise (w_shift_flag)
    );

    assign w_order     = bit_order_e'(lsb_first);
    assign w_last_data = (r_bit_cnt == CNT_W'(WIDTH - 1));

    // Candidate next shift-register values for a rotate and for a data insert.
    always_comb begin
        w_rot = r_shreg;
        w_ins = r_shreg;
        if (w_order == LSB_FIRST) begin
            w_rot = {r_shreg[0], r_shreg[WIDTH-1:1]};
            w_ins = {datain, r_shreg[WIDTH-1:1]};
        end else begin
            w_rot = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
            w_ins = {r_shreg[WIDTH-2:0], datain};
        end
    end

`ifdef DEPACK_PARITY_EN
    logic r_par_acc;
    logic r_parity_err;
    logic w_par_phase;

    assign w_par_phase = (r_bit_cnt == CNT_W'(WIDTH));

    // Parity tracks bits as received, so a rotate before the parity slot does not disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg       <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_bit_cnt     <= '0;
            r_par_acc     <= 1'b0;
            r_parity_err  <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (clr) begin
                r_shreg      <= '0;
                r_bit_cnt    <= '0;
                r_par_acc    <= 1'b0;
                r_parity_err <= 1'b0;
            end else if (w_shift_flag) begin
                r_shreg <= w_rot;
            end else if (en) begin
                if (w_par_phase) begin
                    r_frame_data  <= r_shreg;
                    r_frame_valid <= 1'b1;
                    r_bit_cnt     <= '0;
                    r_par_acc     <= 1'b0;
                    r_parity_err  <= ((r_par_acc ^ datain) != ODD_PARITY);
                end else begin
                    r_shreg   <= w_ins;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    r_par_acc <= r_par_acc ^ datain;
                end
            end
        end
    end

    assign parity_err = r_parity_err;
`else
    logic w_unused_parity_sense;

    assign w_unused_parity_sense = ODD_PARITY ^ w_last_data;

    // Frame completes on the en that delivers bit WIDTH; the latch takes the post-insert value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg       <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_bit_cnt     <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            if (clr) begin
                r_shreg   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift_flag) begin
                r_shreg <= w_rot;
            end else if (en) begin
                r_shreg <= w_ins;
                if (w_last_data) begin
                    r_frame_data  <= w_ins;
                    r_frame_valid <= 1'b1;
                    r_bit_cnt     <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end
`endif

    assign dataout     = r_shreg;
    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign bit_cnt     = r_bit_cnt;

endmodule

// File: tb/tb_demo_depack_n.sv
// Directed bench for demo_depack_n (WIDTH=8) with a frame scoreboard; DEPACK_PARITY_EN aware.
module tb_demo_depack_n;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = demo_depack_pkg::cnt_w(W);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             datain = 1'b0;
    logic             shift = 1'b0;
    logic             lsb_first = 1'b0;
    logic             clr = 1'b0;
    logic [W-1:0]     dataout;
    logic [W-1:0]     frame_data;
    logic             frame_valid;
    logic [CNT_W-1:0] bit_cnt;
`ifdef DEPACK_PARITY_EN
    logic             parity_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    demo_depack_n #(.WIDTH(W), .ODD_PARITY(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .datain      (datain),
        .shift       (shift),
        .lsb_first   (lsb_first),
        .clr         (clr),
        .dataout     (dataout),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .bit_cnt     (bit_cnt)
`ifdef DEPACK_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge with the bit sampled.
    task automatic send_bit(input logic b);
        en     = 1'b1;
        datain = b;
        @(negedge clk);
        en     = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic lsb);
        lsb_first = lsb;
        exp_q.push_back(data);
        for (int i = 0; i < int'(W); i++) begin
            send_bit(lsb ? data[i] : data[W-1-i]);
        end
`ifdef DEPACK_PARITY_EN
        chk("par_wait_cnt", 64'(bit_cnt), 64'(W));
        chk("par_wait_valid", 64'(frame_valid), 64'd0);
        send_bit(^data);
        chk("par_ok", 64'(parity_err), 64'd0);
`endif
        chk("frame_valid_hi", 64'(frame_valid), 64'd1);
        chk("cnt_after_frame", 64'(bit_cnt), 64'd0);
    endtask

    // Scoreboard: every frame_valid pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (!rst && frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("valid_without_frame", 64'(frame_valid), 64'd0);
            end else begin
                chk("frame_data", 64'(frame_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_dataout", 64'(dataout), 64'd0);
        chk("rst_frame_data", 64'(frame_data), 64'd0);
        chk("rst_valid", 64'(frame_valid), 64'd0);
        chk("rst_cnt", 64'(bit_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_dataout", 64'(dataout), 64'd0);

        // MSB-first frame 1,0,1,0,0,1,0,1
        send_frame(8'hA5, 1'b0);
        chk("msb_dataout", 64'(dataout), 64'hA5);
        @(negedge clk);
        chk("valid_one_cycle", 64'(frame_valid), 64'd0);
        chk("frame_held", 64'(frame_data), 64'hA5);

        // LSB-first 0,1,1,1,1,0,0,0
        send_frame(8'h1E, 1'b1);
        chk("lsb_dataout", 64'(dataout), 64'h1E);

        // Held shift gives exactly one rotate in each direction
        send_frame(8'hA5, 1'b0);
        lsb_first = 1'b0;
        shift     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rotl_held", 64'(dataout), 64'h4B);
        end
        shift = 1'b0;
        @(negedge clk);
        lsb_first = 1'b1;
        shift     = 1'b1;
        @(negedge clk);
        chk("rotr_back", 64'(dataout), 64'hA5);
        shift = 1'b0;
        @(negedge clk);
        shift = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rotr_held", 64'(dataout), 64'hD2);
        end
        shift = 1'b0;
        @(negedge clk);
        chk("rot_cnt", 64'(bit_cnt), 64'd0);

        // Rotate beats a concurrent en; clr beats both
        lsb_first = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("three_bits_cnt", 64'(bit_cnt), 64'd3);
        chk("three_bits_data", 64'(dataout), 64'h96);
        en     = 1'b1;
        datain = 1'b1;
        shift  = 1'b1;
        @(negedge clk);
        en    = 1'b0;
        shift = 1'b0;
        chk("en_shift_data", 64'(dataout), 64'h2D);
        chk("en_shift_cnt", 64'(bit_cnt), 64'd3);
        @(negedge clk);
        clr    = 1'b1;
        en     = 1'b1;
        datain = 1'b1;
        shift  = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        en    = 1'b0;
        shift = 1'b0;
        chk("clr_data", 64'(dataout), 64'd0);
        chk("clr_cnt", 64'(bit_cnt), 64'd0);
        chk("clr_frame_kept", 64'(frame_data), 64'hA5);
        chk("clr_valid", 64'(frame_valid), 64'd0);

        // Async reset mid-frame, then a clean frame
        lsb_first = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("five_bits_cnt", 64'(bit_cnt), 64'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", 64'(dataout), 64'd0);
        chk("async_rst_cnt", 64'(bit_cnt), 64'd0);
        chk("async_rst_frame", 64'(frame_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'hC3, 1'b0);
        chk("after_rst_data", 64'(dataout), 64'hC3);

`ifdef DEPACK_PARITY_EN
        // Wrong parity bit on an even-weight word
        lsb_first = 1'b0;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < int'(W); i++) begin
            send_bit(8'hA5 >> (W - 1 - i) & 8'h01 ? 1'b1 : 1'b0);
        end
        chk("bad_par_wait", 64'(frame_valid), 64'd0);
        send_bit(1'b1);
        chk("bad_par_valid", 64'(frame_valid), 64'd1);
        chk("bad_par_err", 64'(parity_err), 64'd1);
        @(negedge clk);
        chk("bad_par_held", 64'(parity_err), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("par_err_clr", 64'(parity_err), 64'd0);
`endif

        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
